// File: rtl/array_arbiter_pkg.sv
// Shared types for the LC-3b cache metadata array arbiter.
package lc3b_types;

    typedef logic [4:0] lc3b_arr_index;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/array_arbiter_rr_select.sv
// Two-way round-robin picker: on contention the port that did not win last time goes.
module rr_select (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    // Pick a winner from the two request lines.
    always_comb begin
        grant_valid = req[0] | req[1];
        case (req)
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'b1;
            2'b01:   grant = 1'b0;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/array_arbiter.sv
// Shares one metadata array between two requesters and zero-fills it after every reset.
module array_arbiter
    import lc3b_types::*;
#(
    parameter int width  = 16,
    parameter int height = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0_read,
    input  logic                req0_write,
    input  lc3b_arr_index       req0_index,
    input  logic [width-1:0]    req0_wdata,
    output logic                resp0,
    output logic [width-1:0]    req0_rdata,
    input  logic                req1_read,
    input  logic                req1_write,
    input  lc3b_arr_index       req1_index,
    input  logic [width-1:0]    req1_wdata,
    output logic                resp1,
    output logic [width-1:0]    req1_rdata,
    output logic                busy,
    output logic                arr_write,
    output lc3b_arr_index       arr_index_in,
    output lc3b_arr_index       arr_index_out,
    output logic [width-1:0]    arr_datain,
    input  logic [width-1:0]    arr_dataout
);

    localparam lc3b_arr_index LAST_INDEX = lc3b_arr_index'(height - 1);

    arb_state_t         state_r;
    lc3b_arr_index      counter_r;
    lc3b_arr_index      index_r;
    logic [width-1:0]   data_r;
    logic               busy_r;
    logic               resp0_r;
    logic               resp1_r;
    logic [width-1:0]   rdata0_r;
    logic [width-1:0]   rdata1_r;
    logic               last_grant_r;
    logic               owner_r;
    logic               owner_write_r;

    logic [1:0]         req_s;
    logic               grant_valid_s;
    logic               grant_s;

    assign req_s = {req1_read | req1_write, req0_read | req0_write};

    rr_select u_rr_select (
        .req         (req_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Sweep, arbitration and access sequencing; array index/data are registered and held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= INIT;
            counter_r     <= 5'd0;
            index_r       <= 5'd0;
            data_r        <= '0;
            busy_r        <= 1'b1;
            resp0_r       <= 1'b0;
            resp1_r       <= 1'b0;
            rdata0_r      <= '0;
            rdata1_r      <= '0;
            last_grant_r  <= 1'b1;
            owner_r       <= 1'b0;
            owner_write_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    data_r <= '0;
                    if (counter_r == LAST_INDEX) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        counter_r <= counter_r + 5'd1;
                        index_r   <= counter_r + 5'd1;
                    end
                end
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r       <= grant_s;
                        owner_write_r <= grant_s ? req1_write : req0_write;
                        index_r       <= grant_s ? req1_index : req0_index;
                        data_r        <= grant_s ? req1_wdata : req0_wdata;
                        state_r       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Capture happens on the same edge as the write, so rdata is the pre-write value.
                    if (owner_r) begin
                        rdata1_r <= arr_dataout;
                        resp1_r  <= 1'b1;
                    end else begin
                        rdata0_r <= arr_dataout;
                        resp0_r  <= 1'b1;
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    resp0_r      <= 1'b0;
                    resp1_r      <= 1'b0;
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

    // Write enable follows state directly so it is already high while reset is held.
    always_comb begin
        case (state_r)
            INIT:    arr_write = 1'b1;
            ACCESS:  arr_write = owner_write_r;
            default: arr_write = 1'b0;
        endcase
    end

    assign arr_index_in  = index_r;
    assign arr_index_out = index_r;
    assign arr_datain    = data_r;
    assign busy          = busy_r;
    assign resp0         = resp0_r;
    assign resp1         = resp1_r;
    assign req0_rdata    = rdata0_r;
    assign req1_rdata    = rdata1_r;

endmodule

// File: tb/tb_array_arbiter.sv
// Directed bench for array_arbiter with a behavioural 32-entry array attached.
module tb_array_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_read = 1'b0, req0_write = 1'b0;
    logic [4:0]  req0_index = 5'd0;
    logic [15:0] req0_wdata = 16'h0000;
    logic        resp0;
    logic [15:0] req0_rdata;
    logic        req1_read = 1'b0, req1_write = 1'b0;
    logic [4:0]  req1_index = 5'd0;
    logic [15:0] req1_wdata = 16'h0000;
    logic        resp1;
    logic [15:0] req1_rdata;
    logic        busy;
    logic        arr_write;
    logic [4:0]  arr_index_in, arr_index_out;
    logic [15:0] arr_datain, arr_dataout;

    logic [15:0] mem [32];
    logic        preload = 1'b1;
    int          resp0_cnt = 0, resp1_cnt = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    array_arbiter #(.width(16), .height(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_read(req0_read), .req0_write(req0_write), .req0_index(req0_index),
        .req0_wdata(req0_wdata), .resp0(resp0), .req0_rdata(req0_rdata),
        .req1_read(req1_read), .req1_write(req1_write), .req1_index(req1_index),
        .req1_wdata(req1_wdata), .resp1(resp1), .req1_rdata(req1_rdata),
        .busy(busy), .arr_write(arr_write), .arr_index_in(arr_index_in),
        .arr_index_out(arr_index_out), .arr_datain(arr_datain), .arr_dataout(arr_dataout)
    );

    // Array model: nonzero preset contents, synchronous write, combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'hA5A5 ^ 16'(i);
        end else if (arr_write) begin
            mem[arr_index_in] <= arr_datain;
        end
    end
    assign arr_dataout = mem[arr_index_out];

    always @(negedge clk) begin
        resp0_cnt <= resp0_cnt + int'(resp0);
        resp1_cnt <= resp1_cnt + int'(resp1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_access(input int port, input logic rd, input logic wr, input logic [4:0] idx,
                             input logic [15:0] wd, output logic [15:0] rdata, output int lat);
        logic seen;
        if (port == 1) begin
            req1_read = rd; req1_write = wr; req1_index = idx; req1_wdata = wd;
        end else begin
            req0_read = rd; req0_write = wr; req0_index = idx; req0_wdata = wd;
        end
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = (port == 1) ? resp1 : resp0;
        end
        rdata = (port == 1) ? req1_rdata : req0_rdata;
        req0_read = 1'b0; req0_write = 1'b0; req1_read = 1'b0; req1_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        int n;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sweep_cycles"}, n, 32);
    endtask

    initial begin
        logic [15:0] rd;
        int lat, writes, bad_idx, bad_mem, n;
        int ev_port [4];
        int ev_k [4];
        logic [15:0] ev_rd [4];

        // Reset state
        repeat (3) @(negedge clk);
        preload = 1'b0;
        #1;
        check("rst_busy", busy, 1);
        check("rst_resp", {resp1, resp0}, 0);
        check("rst_rdata", {req1_rdata, req0_rdata}, 0);
        check("rst_arr_write", arr_write, 1);

        // Sweep after release
        @(negedge clk);
        reset_n = 1'b1;
        writes = 0; bad_idx = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (arr_write) writes++;
            if (arr_index_in != 5'(c) || arr_index_out != 5'(c) || arr_datain != 16'h0000) bad_idx++;
            if (c == 31) check("busy_last_sweep", busy, 1);
            @(negedge clk);
        end
        check("sweep_writes", writes, 32);
        check("sweep_index_data", bad_idx, 0);
        check("idle_busy", busy, 0);
        check("idle_arr_write", arr_write, 0);
        check("idle_index_hold", arr_index_in, 31);
        bad_mem = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 16'h0000) bad_mem++;
        check("sweep_zeroed", bad_mem, 0);

        // Port 0 write then read
        do_access(0, 1'b0, 1'b1, 5'd5, 16'h1234, rd, lat);
        check("p0_wr_lat", lat, 2);
        do_access(0, 1'b1, 1'b0, 5'd5, 16'h0000, rd, lat);
        check("p0_rd_lat", lat, 2);
        check("p0_rd_data", rd, 16'h1234);
        check("p1_no_resp", resp1_cnt, 0);

        // Contention from a fresh reset
        do_reset("r2");
        req0_read = 1'b1; req0_index = 5'd3;
        req1_write = 1'b1; req1_index = 5'd3; req1_wdata = 16'hBEEF;
        n = 0;
        for (int k = 1; k <= 40 && n < 4; k++) begin
            @(negedge clk);
            if (resp0 || resp1) begin
                ev_port[n] = resp1 ? 1 : 0;
                ev_k[n] = k;
                ev_rd[n] = req0_rdata;
                n++;
            end
        end
        req0_read = 1'b0; req1_write = 1'b0;
        @(negedge clk);
        check("cont_events", n, 4);
        if (n == 4) begin
            check("cont_order", {ev_port[0][3:0], ev_port[1][3:0], ev_port[2][3:0], ev_port[3][3:0]}, 32'h0101);
            check("cont_first_k", ev_k[0], 2);
            check("cont_gap", ev_k[3] - ev_k[0], 9);
            check("cont_rd0", ev_rd[0], 16'h0000);
            check("cont_rd2", ev_rd[2], 16'hBEEF);
        end

        // Read-modify-write on port 1
        do_access(1, 1'b0, 1'b1, 5'd9, 16'h0A0A, rd, lat);
        check("p1_wr_lat", lat, 2);
        do_access(1, 1'b1, 1'b1, 5'd9, 16'h00FF, rd, lat);
        check("rmw_old", rd, 16'h0A0A);
        check("rmw_mem", mem[9], 16'h00FF);
        do_access(0, 1'b1, 1'b0, 5'd9, 16'h0000, rd, lat);
        check("rmw_readback", rd, 16'h00FF);

        // Request raised during the sweep
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!resp0 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                req0_write = 1'b1; req0_index = 5'd31; req0_wdata = 16'h5A5A;
            end
        end
        check("init_req_resp_cycle", n, 34);
        req0_write = 1'b0;
        @(negedge clk);
        do_access(0, 1'b1, 1'b0, 5'd31, 16'h0000, rd, lat);
        check("init_req_readback", rd, 16'h5A5A);

        // Reset asserted during ACCESS
        req0_write = 1'b1; req0_index = 5'd7; req0_wdata = 16'h7777;
        @(negedge clk);
        check("acc_arr_write", arr_write, 1);
        check("acc_index", arr_index_in, 7);
        reset_n = 1'b0;
        n = resp0_cnt;
        #1;
        check("abort_busy", busy, 1);
        check("abort_resp", resp0, 0);
        check("abort_index", arr_index_in, 0);
        req0_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_resp", resp0_cnt - n, 0);
        check("abort_no_write", mem[7], 16'h0000);
        reset_n = 1'b1;
        #1;
        check("restart_idx0", arr_index_in, 0);
        @(negedge clk);
        check("restart_idx1", arr_index_in, 1);
        n = 1;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("restart_sweep_cycles", n, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
